// File: rtl/div_nr_sequencer.sv
// ---------------------------------------------------------------------------
// div_nr_sequencer
//   Multi-cycle controller for the Newton-Raphson mantissa divider. Owns the
//   iteration registers (x, A, E, Eb, Da, Db) and steps the external shared
//   58x58 multiplier through seed, Newton and quotient phases.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             divide request, sampled only in IDLE
//   db                1 = double (3 Newton iterations), 0 = single (2)
//   fa, fb            dividend / divisor significands (53 bits)
//   busy              high in every state except IDLE
//   done              one-cycle pulse, Da/Db/E/Eb valid
//   rom_addr/rom_data async reciprocal seed ROM lookup
//   mul_a, mul_b      registered multiplier operands
//   mul_out           multiplier product (MUL_LAT extra cycles after operands)
//   Da, Db, E, Eb     results toward the fd-select stage
//   last_cycles       (only with DIV_CYCLE_CNT_EN) latency of the last divide
//   state_dbg         current FSM state for debug/checkers
//
// Optional feature macro: DIV_CYCLE_CNT_EN
//
// Handshake: start is a level request; it is accepted on the rising edge at
// which the FSM is in IDLE and start is high. From that edge busy stays high
// until (and including) the single done cycle; start is ignored while busy,
// with no queuing. A new request may be accepted in the first IDLE cycle.
// ---------------------------------------------------------------------------
module div_nr_sequencer #(
  parameter int MUL_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         db,
  input  logic [52:0]  fa,
  input  logic [52:0]  fb,
  output logic         busy,
  output logic         done,
  output logic [7:0]   rom_addr,
  input  logic [7:0]   rom_data,
  output logic [57:0]  mul_a,
  output logic [57:0]  mul_b,
  input  logic [115:0] mul_out,
  output logic [57:0]  Da,
  output logic [57:0]  Db,
  output logic [54:0]  E,
  output logic [115:0] Eb,
`ifdef DIV_CYCLE_CNT_EN
  output logic [7:0]   last_cycles,
`endif
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEED = 3'd1,
    S_NR1  = 3'd2,
    S_NR2  = 3'd3,
    S_Q1   = 3'd4,
    S_Q2   = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [52:0] fa_q, fb_q;
  logic        db_q;
  logic [1:0]  dcnt;
  logic [1:0]  wcnt;
  logic [57:0] x, A;
  logic [57:0] mul_hi;
  logic [54:0] enew;
  logic        wait_hit;

  // Product is ready once the operands have been held for MUL_LAT extra cycles.
  assign wait_hit = (wcnt == MUL_LAT[1:0]);
  assign mul_hi   = mul_out[115:58];
  // Single precision drops the low 29 quotient bits.
  assign enew     = {mul_out[115:90], mul_out[89:61] & {29{db_q}}};
  assign rom_addr = fb_q[51:44];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start)    state_nxt = S_SEED;
      S_SEED:               state_nxt = S_NR1;
      S_NR1:  if (wait_hit) state_nxt = S_NR2;
      S_NR2:  if (wait_hit) state_nxt = (dcnt == 2'd1) ? S_Q1 : S_NR1;
      S_Q1:   if (wait_hit) state_nxt = S_Q2;
      S_Q2:   if (wait_hit) state_nxt = S_FIN;
      S_FIN:                state_nxt = S_IDLE;
      default:              state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_FIN);
    state_dbg = state;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fa_q  <= '0;
      fb_q  <= '0;
      db_q  <= 1'b0;
      dcnt  <= '0;
      wcnt  <= '0;
      x     <= '0;
      A     <= '0;
      mul_a <= '0;
      mul_b <= '0;
      Da    <= '0;
      Db    <= '0;
      E     <= '0;
      Eb    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            fa_q <= fa;
            fb_q <= fb;
            db_q <= db;
            dcnt <= db ? 2'd3 : 2'd2;
          end
        end
        S_SEED: begin
          x     <= {2'b01, rom_data, 48'b0};
          mul_a <= {2'b01, rom_data, 48'b0};
          mul_b <= {fb_q, 5'b0};
          wcnt  <= '0;
        end
        S_NR1, S_NR2, S_Q1, S_Q2: begin
          if (!wait_hit) begin
            wcnt <= wcnt + 2'd1;
          end else begin
            wcnt <= '0;
            case (state)
              S_NR1: begin
                // A = 2 - x*b, approximated by one's complement
                A     <= ~mul_hi;
                mul_a <= ~mul_hi;
                mul_b <= x;
              end
              S_NR2: begin
                x    <= mul_hi;
                dcnt <= dcnt - 2'd1;
                if (dcnt == 2'd1) begin
                  mul_a <= {fa_q, 5'b0};
                  mul_b <= mul_hi;
                end else begin
                  mul_a <= mul_hi;
                  mul_b <= {fb_q, 5'b0};
                end
              end
              S_Q1: begin
                E     <= enew;
                mul_a <= {enew, 3'b0};
                mul_b <= {fb_q, 5'b0};
                Da    <= {fa_q, 5'b0};
                Db    <= {fb_q, 5'b0};
              end
              default: begin
                Eb <= mul_out;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_CYCLE_CNT_EN
  logic [7:0] cyc_cnt;

  // Counts every busy cycle since acceptance; in FIN it equals the latency N.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt     <= '0;
      last_cycles <= '0;
    end else begin
      if (state == S_IDLE && start) cyc_cnt <= '0;
      else if (busy)                cyc_cnt <= cyc_cnt + 8'd1;
      if (state == S_FIN)           last_cycles <= cyc_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_div_nr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_div_nr_sequencer
//   Directed self-checking bench for div_nr_sequencer with a behavioural
//   multiplier (MUL_LAT pipeline stages) and a simple reciprocal ROM.
// ---------------------------------------------------------------------------
module tb_div_nr_sequencer;

`ifdef DIV_CYCLE_CNT_EN
  localparam int L = 0;
`else
  localparam int L = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         db;
  logic [52:0]  fa, fb;
  logic         busy, done;
  logic [7:0]   rom_addr, rom_data;
  logic [57:0]  mul_a, mul_b;
  logic [115:0] mul_out;
  logic [57:0]  Da, Db;
  logic [54:0]  E;
  logic [115:0] Eb;
  logic [2:0]   state_dbg;
`ifdef DIV_CYCLE_CNT_EN
  logic [7:0]   last_cycles;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Results captured by the driver
  int           r_dcyc, r_ndone, r_busy_err;
  logic [57:0]  r_seed_a, r_seed_b;
  logic [7:0]   r_raddr;

  div_nr_sequencer #(.MUL_LAT(L)) dut (
    .clk(clk), .rst(rst), .start(start), .db(db), .fa(fa), .fb(fb),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .Da(Da), .Db(Db), .E(E), .Eb(Eb),
`ifdef DIV_CYCLE_CNT_EN
    .last_cycles(last_cycles),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [115:0] prod_c, prod_q;
  assign prod_c   = {58'b0, mul_a} * {58'b0, mul_b};
  always_ff @(posedge clk) prod_q <= prod_c;
  assign mul_out  = (L == 0) ? prod_c : prod_q;
  assign rom_data = 8'hFF - rom_addr;

  function automatic int exp_n(input logic d);
    return 1 + (2 * (d ? 3 : 2) + 2) * (L + 1);
  endfunction

  // Arithmetic golden model of the full iteration
  function automatic void gold(input logic [52:0] a, input logic [52:0] b,
                               input logic d, output logic [54:0] e,
                               output logic [115:0] eb);
    logic [57:0]  x, aa, dd, da;
    logic [115:0] p;
    x  = {2'b01, 8'hFF - b[51:44], 48'b0};
    dd = {b, 5'b0};
    da = {a, 5'b0};
    for (int i = 0; i < (d ? 3 : 2); i++) begin
      p  = {58'b0, x} * {58'b0, dd};
      aa = ~p[115:58];
      p  = {58'b0, aa} * {58'b0, x};
      x  = p[115:58];
    end
    p  = {58'b0, da} * {58'b0, x};
    e  = {p[115:90], p[89:61] & {29{d}}};
    eb = {58'b0, e, 3'b0} * {58'b0, dd};
  endfunction

  // ---------------- driver ----------------
  // Starts one operation and watches up to 60 edges. tail = cycles kept after
  // the done cycle (0 returns while in FIN). hold keeps start high through FIN.
  task automatic do_op(input logic [52:0] a, input logic [52:0] b,
                       input logic d, input bit hold, input int tail);
    fa = a; fb = b; db = d; start = 1'b1;
    r_dcyc = -1; r_ndone = 0; r_busy_err = 0;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        r_seed_a = mul_a; r_seed_b = mul_b; r_raddr = rom_addr;
      end
      if (done) begin
        r_ndone++;
        if (r_dcyc < 0) r_dcyc = k;
      end
      if ((r_dcyc < 0 || k == r_dcyc) ? (busy !== 1'b1) : (busy !== 1'b0))
        r_busy_err++;
      if (hold && r_dcyc >= 0 && k == r_dcyc + 1) start = 1'b0;
      if (r_dcyc >= 0 && k >= r_dcyc + tail) break;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; start = 1'b0; db = 1'b0; fa = '0; fb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    chk_cnt++; if ({mul_a, mul_b} !== 116'b0) $display("FAIL reset_mul: got %h %h want 0", mul_a, mul_b); else pass_cnt++;
    chk_cnt++; if ({Da, Db} !== 116'b0) $display("FAIL reset_dadb: got %h %h want 0", Da, Db); else pass_cnt++;
    chk_cnt++; if (E !== 55'b0 || Eb !== 116'b0) $display("FAIL reset_e: got %h %h want 0", E, Eb); else pass_cnt++;
`ifdef DIV_CYCLE_CNT_EN
    chk_cnt++; if (last_cycles !== 8'd0) $display("FAIL reset_last_cycles: got %0d want 0", last_cycles); else pass_cnt++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [54:0]  e_exp;
    logic [115:0] eb_exp;
    gold(53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 1'b0, e_exp, eb_exp);
    do_op(53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 1'b0, 1'b0, 3);
    chk_cnt++; if (r_seed_a !== 58'h1FF_0000_0000_0000) $display("FAIL single_seed_a: got %h want 1ff000000000000", r_seed_a); else pass_cnt++;
    chk_cnt++; if (r_seed_b !== 58'h200_0000_0000_0000) $display("FAIL single_seed_b: got %h want 200000000000000", r_seed_b); else pass_cnt++;
    chk_cnt++; if (r_raddr !== 8'h00) $display("FAIL single_rom_addr: got %h want 00", r_raddr); else pass_cnt++;
    chk_cnt++; if (r_dcyc !== exp_n(1'b0)) $display("FAIL single_latency: got %0d want %0d", r_dcyc, exp_n(1'b0)); else pass_cnt++;
    chk_cnt++; if (r_ndone !== 1) $display("FAIL single_done_count: got %0d want 1", r_ndone); else pass_cnt++;
    chk_cnt++; if (r_busy_err !== 0) $display("FAIL single_busy: got %0d bad cycles want 0", r_busy_err); else pass_cnt++;
    chk_cnt++; if (E[28:0] !== 29'b0) $display("FAIL single_e_low: got %h want 0", E[28:0]); else pass_cnt++;
    chk_cnt++; if (E !== e_exp) $display("FAIL single_e: got %h want %h", E, e_exp); else pass_cnt++;
    chk_cnt++; if (Eb !== eb_exp) $display("FAIL single_eb: got %h want %h", Eb, eb_exp); else pass_cnt++;
    chk_cnt++; if (Da !== 58'h200_0000_0000_0000 || Db !== 58'h200_0000_0000_0000)
      $display("FAIL single_dadb: got %h %h want 200000000000000", Da, Db); else pass_cnt++;
`ifdef DIV_CYCLE_CNT_EN
    chk_cnt++; if (last_cycles !== 8'd7) $display("FAIL last_cycles: got %0d want 7", last_cycles); else pass_cnt++;
`endif
  endtask

  task automatic test_double;
    logic [54:0]  e_exp;
    logic [115:0] eb_exp;
    gold(53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 1'b1, e_exp, eb_exp);
    do_op(53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 1'b1, 1'b0, 3);
    chk_cnt++; if (r_dcyc !== exp_n(1'b1)) $display("FAIL double_latency: got %0d want %0d", r_dcyc, exp_n(1'b1)); else pass_cnt++;
    chk_cnt++; if (r_busy_err !== 0) $display("FAIL double_busy: got %0d bad cycles want 0", r_busy_err); else pass_cnt++;
    chk_cnt++; if (E !== e_exp) $display("FAIL double_e: got %h want %h", E, e_exp); else pass_cnt++;
    chk_cnt++; if (Eb !== eb_exp) $display("FAIL double_eb: got %h want %h", Eb, eb_exp); else pass_cnt++;
  endtask

  task automatic test_hold_start;
    do_op(53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 1'b0, 1'b1, 4);
    chk_cnt++; if (r_ndone !== 1) $display("FAIL hold_done_count: got %0d want 1", r_ndone); else pass_cnt++;
    chk_cnt++; if (r_dcyc !== exp_n(1'b0)) $display("FAIL hold_latency: got %0d want %0d", r_dcyc, exp_n(1'b0)); else pass_cnt++;
    chk_cnt++; if (r_busy_err !== 0) $display("FAIL hold_fin_ignored: got %0d bad cycles want 0", r_busy_err); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [54:0]  e_exp;
    logic [115:0] eb_exp;
    gold(53'h1A_BCDE_F012_3456, 53'h18_0000_0000_0000, 1'b1, e_exp, eb_exp);
    do_op(53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 1'b0, 1'b0, 0);
    chk_cnt++; if (done !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", done); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle: got busy %b want 0", busy); else pass_cnt++;
    do_op(53'h1A_BCDE_F012_3456, 53'h18_0000_0000_0000, 1'b1, 1'b0, 3);
    chk_cnt++; if (r_dcyc !== exp_n(1'b1)) $display("FAIL b2b_latency: got %0d want %0d", r_dcyc, exp_n(1'b1)); else pass_cnt++;
    chk_cnt++; if (r_raddr !== 8'h80) $display("FAIL b2b_rom_addr: got %h want 80", r_raddr); else pass_cnt++;
    chk_cnt++; if (E !== e_exp) $display("FAIL b2b_e: got %h want %h", E, e_exp); else pass_cnt++;
    chk_cnt++; if (Eb !== eb_exp) $display("FAIL b2b_eb: got %h want %h", Eb, eb_exp); else pass_cnt++;
    chk_cnt++; if (Da !== {53'h1A_BCDE_F012_3456, 5'b0}) $display("FAIL b2b_da: got %h want %h", Da, {53'h1A_BCDE_F012_3456, 5'b0}); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    fa = 53'h10_0000_0000_0000; fb = 53'h10_0000_0000_0000; db = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // SEED, NR1 wait, NR1 capture -> NR2 after the third edge (L=1);
    // with L=0 it is reached after the second edge.
    repeat ((L == 0) ? 2 : 3) @(posedge clk);
    #1;
    chk_cnt++; if (state_dbg !== 3'd3) $display("FAIL mid_in_nr2: got %0d want 3", state_dbg); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_cnt++; if (busy !== 1'b0 || state_dbg !== 3'd0) $display("FAIL mid_reset_idle: got busy %b state %0d want 0 0", busy, state_dbg); else pass_cnt++;
    chk_cnt++; if ({mul_a, mul_b} !== 116'b0 || E !== 55'b0 || Eb !== 116'b0 || Da !== 58'b0)
      $display("FAIL mid_reset_regs: got %h %h %h want 0", mul_a, E, Da); else pass_cnt++;
    for (int k = 0; k < 20; k++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk_cnt++; if (ndone !== 0) $display("FAIL mid_no_done: got %0d pulses want 0", ndone); else pass_cnt++;
    do_op(53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 1'b0, 1'b0, 3);
    chk_cnt++; if (r_dcyc !== exp_n(1'b0)) $display("FAIL mid_after_latency: got %0d want %0d", r_dcyc, exp_n(1'b0)); else pass_cnt++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_single;
    test_double;
    test_hold_start;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/div_nr_sequencer.md
Name: div_nr_sequencer

Overview:
- Multi-cycle controller for the Newton-Raphson mantissa divider.
- Owns the iteration registers: x, A, E, Eb, Da, Db.
- Sequences the shared 58x58 multiplier tree, which is external to this block, through seed, Newton and quotient phases.
- Presents the final Da/Db/E/Eb to the fd-select stage, with a start/busy/done handshake toward the FPU issue logic.

Parameters:
- MUL_LAT, 1, extra multiplier pipeline cycles (0..3); 0 = combinational multiplier.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a divide; sampled only in IDLE
- db  in  1  1 = double precision (3 Newton iterations), 0 = single (2 iterations)
- fa  in  53  dividend significand
- fb  in  53  divisor significand
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; Da/Db/E/Eb valid
- rom_addr  out  8  fb_q[51:44] to the async reciprocal ROM
- rom_data  in  8  ROM seed, valid in the same cycle as rom_addr
- mul_a  out  58  multiplier operand A (registered)
- mul_b  out  58  multiplier operand B (registered)
- mul_out  in  116  multiplier product
- Da  out  58  {fa_q,5'b0}
- Db  out  58  {fb_q,5'b0}
- E  out  55  quotient estimate
- Eb  out  116  E times divisor product

Behaviour:
- Reset: state IDLE. busy=0, done=0. mul_a, mul_b, Da, Db, E, Eb, x, A, fa_q, fb_q, dcnt and wcnt all 0.
- IDLE, on start:
  - latch fa_q, fb_q, db_q;
  - dcnt <= db ? 3 : 2;
  - go to SEED.
- SEED:
  - x <= {2'b01, rom_data, 48'b0};
  - mul_a <= that same value; mul_b <= {fb_q,5'b0};
  - wcnt <= 0; go to NR1.
- Wait rule (NR1, NR2, Q1, Q2): wcnt increments each cycle; the capture action fires on the cycle where wcnt==MUL_LAT, then wcnt <= 0 and the state advances.
- NR1 capture:
  - A <= ~mul_out[115:58];
  - mul_a <= ~mul_out[115:58]; mul_b <= x;
  - go to NR2.
- NR2 capture:
  - x <= mul_out[115:58]; dcnt <= dcnt-1.
  - If dcnt==1: mul_a <= {fa_q,5'b0}, mul_b <= mul_out[115:58], go to Q1.
  - Else: mul_a <= mul_out[115:58], mul_b <= {fb_q,5'b0}, go to NR1.
- Q1 capture:
  - Enew = {mul_out[115:90], mul_out[89:61] & {29{db_q}}}; E <= Enew;
  - mul_a <= {Enew,3'b0}; mul_b <= {fb_q,5'b0};
  - Da <= {fa_q,5'b0}; Db <= {fb_q,5'b0};
  - go to Q2.
- Q2 capture: Eb <= mul_out; go to FIN.
- FIN: done=1 for exactly this cycle, busy=1; next state IDLE.
- Latency: done is high in the cycle following edge N after the start-sampling edge.
  - N = 1 + (2n+2)(MUL_LAT+1), where n = iteration count.
  - Single precision, MUL_LAT=1: N=13. Double precision, MUL_LAT=1: N=17.
- Single precision: E[28:0] is always 0.
- start outside IDLE, including during FIN, is ignored; no queuing.
- Back-to-back: start in the first IDLE cycle after FIN is accepted.
- Da/Db/E/Eb hold their values until the next operation overwrites them.
- fa, fb and db are not sampled after acceptance.
- rst mid-operation: next state IDLE, every register at its reset value, no done pulse.
- rom_addr is combinational from fb_q.

Optional Feature:
- Macro: DIV_CYCLE_CNT_EN.
- Defined:
  - adds output last_cycles [7:0], reset 0;
  - an internal counter clears on start acceptance and increments each busy cycle;
  - last_cycles is loaded with the counter value in FIN, so it equals N.
- Undefined: no port and no counter logic.

Test Plan:
- Reset: assert rst for 2 cycles -> busy=0, done=0, mul_a=mul_b=E=Eb=Da=Db=0.
- Single, MUL_LAT=1: fa=fb=53'h10_0000_0000_0000, rom_data=8'hFF, behavioural multiplier model.
  - SEED loads mul_a=58'h1FF_0000_0000_0000 and mul_b=58'h200_0000_0000_0000.
  - rom_addr=8'h00.
  - done pulses at N=13, busy high for cycles 1..13.
  - E[28:0]=0.
  - E/Eb match the golden model.
- Double, MUL_LAT=1, same operands, db=1 -> 8 multiplier captures, done at N=17, E/Eb match the golden model.
- Handshake:
  - start held high throughout an operation -> exactly one operation.
  - start held high through FIN -> ignored.
  - start in the cycle after FIN -> second operation accepted; done at the expected N.
- Reset while in NR2 of a double operation -> next cycle IDLE, busy=0, no done; a following single operation completes at N=13.
- DIV_CYCLE_CNT_EN defined, MUL_LAT=0, single -> done at N=7 and last_cycles=7.
